sort_engine: RTL and testbench
==============================

# sort_engine

- Parametrised in-place bubble-sort engine: a successor to the fixed-size bubble-sort CONTROL FSM.
- Owns the compare/swap datapath and a memory port to an external single-port synchronous RAM.
- Sorts the first `n` words of that RAM ascending or descending.
- Reports completion with a `done` pulse and a swap count, and exposes its state code for debug.

## Interface
- `DATA_W`, default 8: element width in bits, compared as unsigned.
- `DEPTH`, default 16: maximum number of elements.
- `ADDR_W`, default 4: RAM address width; DEPTH ≤ 2^ADDR_W.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a sort; sampled only in IDLE.
- `descend` in 1: 0 = ascending, 1 = descending; sampled with `start`.
- `n` in ADDR_W+1: element count; sampled with `start`.
- `mem_addr` out ADDR_W: RAM address.
- `mem_rd` out 1: RAM read strobe.
- `mem_wr` out 1: RAM write strobe.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after `mem_rd`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `swap_cnt` out 2*ADDR_W: swaps performed by the current or last sort.
- `state_out` out 4: current state code.

## Operation
- State codes:
  - IDLE=0, RD_A=1, RD_B=2, LD_B=3, CMP=4, WR_A=5, WR_B=6, PASS=7, DONE=8.
  - Codes 9–15 are unreachable and decode to IDLE.
- Internal registers:
  - `a`, `b`: DATA_W each.
  - `i`, `j`: ADDR_W each.
  - `swapped`: 1 bit.
  - `n_eff`: effective element count, `min(n, DEPTH)`.
  - `dir`: latched `descend`.
- IDLE, on `start`=1:
  - Latch `dir` and `n_eff`; clear `swap_cnt`.
  - If `n_eff` ≤ 1, go to DONE; no RAM access.
  - Otherwise set `i`=`n_eff`−1, `j`=0, `swapped`=0, and go to RD_A.
- RD_A: `mem_rd`=1, `mem_addr`=j. Go to RD_B.
- RD_B: `mem_rd`=1, `mem_addr`=j+1. Capture `a`⇐`mem_rdata`. Go to LD_B.
- LD_B: capture `b`⇐`mem_rdata`. Go to CMP.
- CMP: swap condition is `dir` ? (`a`<`b`) : (`a`>`b`). Equal values never swap (stable).
  - Swap: go to WR_A.
  - No swap, j=i−1: go to PASS.
  - No swap, otherwise: j⇐j+1 and go to RD_A.
- WR_A: `mem_wr`=1, `mem_addr`=j, `mem_wdata`=`b`. Go to WR_B.
- WR_B: `mem_wr`=1, `mem_addr`=j+1, `mem_wdata`=`a`. Then `swapped`⇐1 and `swap_cnt`+1. Next state follows the CMP no-swap rule.
- PASS: i⇐i−1, j⇐0.
  - If i was 1, or the early-exit condition holds (see Configuration), go to DONE.
  - Otherwise clear `swapped` and go to RD_A.
- DONE: `done`=1 for this cycle, then go to IDLE.
- Strobes: `mem_rd` and `mem_wr` are never high together. Both are 0 in IDLE, LD_B, CMP, PASS and DONE.
- `start` is ignored while `busy`=1. `descend` and `n` may change freely after sampling.
- `swap_cnt` never overflows: n(n−1)/2 < 2^(2·ADDR_W). It holds its value after DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata`, `swap_cnt` = 0; `state_out`=0.
- Reset mid-sort:
  - Returns to IDLE on the next edge; no further RAM writes.
  - RAM may be left partially sorted.
  - A reset during WR_A leaves that pair half-written. This is accepted.
- Start-to-done latency: edge E0 samples `start`, and `done` is high in cycle L after E0, where L = 4·compares + 2·swaps + passes + 1.
- For `n_eff` ≤ 1: L = 1.

## Configuration
- `SORT_EARLY_EXIT_EN` defined:
  - In PASS, `swapped`=0 also terminates (go to DONE).
  - An already-sorted input finishes after one pass.
- `SORT_EARLY_EXIT_EN` undefined:
  - `swapped` is ignored.
  - Exactly `n_eff`−1 passes always run.
  - The `swapped` register may be optimised away.

## Test plan
- n=4, ascending, RAM [3,1,4,2] → RAM [1,2,3,4], `swap_cnt`=3, `done` in cycle 34 after E0 (either config).
- n=4, ascending, RAM [1,2,3,4]:
  - With `SORT_EARLY_EXIT_EN`: `done` in cycle 14, `swap_cnt`=0, no `mem_wr` ever.
  - Without it: `done` in cycle 28.
- n=5, `descend`=1, RAM [2,2,7,0,7] → [7,7,2,2,0]. The two 2s are never swapped with each other.
- n=1, then n=0 → `done` in cycle 1 after E0, `mem_rd`/`mem_wr` never asserted, `swap_cnt`=0.
- n=20 with DEPTH=16 → only addresses 0–15 are accessed and sorted.
- `start` pulsed while busy has no effect.
- `rst_n`=0 during the first WR_A:
  - Next cycle: `state_out`=0, `busy`=0, no further writes.
  - A fresh `start` then sorts correctly.

Source files
------------

// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sort over the first n words of an external
// single-port synchronous RAM (read data valid one cycle after mem_rd).
//
// Optional feature macro: SORT_EARLY_EXIT_EN
//   defined   -> a pass that performs no swap ends the sort early
//   undefined -> exactly n_eff-1 passes always run (no swapped flag kept)
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request a sort (sampled only in IDLE)
//   descend           0 = ascending, 1 = descending (sampled with start)
//   n                 element count, clipped to DEPTH (sampled with start)
//   mem_addr/rd/wr    RAM address and strobes (never rd and wr together)
//   mem_wdata         RAM write data
//   mem_rdata         RAM read data
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   swap_cnt          swaps performed by the current or last sort
//   state_out         current state code
module sort_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  descend,
    input  logic [ADDR_W:0]       n,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [2*ADDR_W-1:0]   swap_cnt,
    output logic [3:0]            state_out
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned SWP_W = 2 * ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(DEPTH);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RD_A = 4'd1,
        RD_B = 4'd2,
        LD_B = 4'd3,
        CMP  = 4'd4,
        WR_A = 4'd5,
        WR_B = 4'd6,
        PASS = 4'd7,
        DONE = 4'd8
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [ADDR_W-1:0]   i;
    logic [ADDR_W-1:0]   j;
    logic                dir;
`ifdef SORT_EARLY_EXIT_EN
    logic                swapped;
`endif

    logic [CNT_W-1:0]    n_eff_c;
    logic [ADDR_W-1:0]   j_inc_c;
    logic                swap_c;
    logic                last_c;
    logic                finish_c;

    // Clip the requested count to the physical depth.
    assign n_eff_c = (n > DEPTH_N) ? DEPTH_N : n;
    assign j_inc_c = j + ADDR_W'(1);
    // Strict comparison: equal elements never swap, keeping the sort stable.
    assign swap_c  = dir ? (a < b) : (a > b);
    assign last_c  = (j == i - ADDR_W'(1));

    // End-of-pass termination test.
`ifdef SORT_EARLY_EXIT_EN
    assign finish_c = (i == ADDR_W'(1)) || !swapped;
`else
    assign finish_c = (i == ADDR_W'(1));
`endif

    assign state_out = state;

    // Controller: outputs are registered together with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            i         <= '0;
            j         <= '0;
            dir       <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swapped   <= 1'b0;
`endif
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            swap_cnt  <= '0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            done   <= 1'b0;
            case (state)
                RD_A: begin
                    state    <= RD_B;
                    mem_rd   <= 1'b1;
                    mem_addr <= j_inc_c;
                end
                RD_B: begin
                    a     <= mem_rdata;
                    state <= LD_B;
                end
                LD_B: begin
                    b     <= mem_rdata;
                    state <= CMP;
                end
                CMP: begin
                    if (swap_c) begin
                        state     <= WR_A;
                        mem_wr    <= 1'b1;
                        mem_addr  <= j;
                        mem_wdata <= b;
                    end else if (last_c) begin
                        state <= PASS;
                    end else begin
                        j        <= j_inc_c;
                        state    <= RD_A;
                        mem_rd   <= 1'b1;
                        mem_addr <= j_inc_c;
                    end
                end
                WR_A: begin
                    state     <= WR_B;
                    mem_wr    <= 1'b1;
                    mem_addr  <= j_inc_c;
                    mem_wdata <= a;
                end
                WR_B: begin
`ifdef SORT_EARLY_EXIT_EN
                    swapped  <= 1'b1;
`endif
                    swap_cnt <= swap_cnt + SWP_W'(1);
                    if (last_c) begin
                        state <= PASS;
                    end else begin
                        j        <= j_inc_c;
                        state    <= RD_A;
                        mem_rd   <= 1'b1;
                        mem_addr <= j_inc_c;
                    end
                end
                PASS: begin
                    i <= i - ADDR_W'(1);
                    j <= '0;
                    if (finish_c) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                        state    <= RD_A;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    // IDLE; unreachable codes recover here as well.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        dir      <= descend;
                        swap_cnt <= '0;
                        busy     <= 1'b1;
                        if (n_eff_c <= CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            i        <= ADDR_W'(n_eff_c - CNT_W'(1));
                            j        <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swapped  <= 1'b0;
`endif
                            state    <= RD_A;
                            mem_rd   <= 1'b1;
                            mem_addr <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Directed self-checking bench for sort_engine with a behavioural
// single-port synchronous RAM. Element k of a packed vector is byte k.
module tb_sort_engine;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            descend;
    logic [AW:0]     n;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic            mem_wr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic            done;
    logic [2*AW-1:0] swap_cnt;
    logic [3:0]      state_out;

    sort_engine #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .descend   (descend),
        .n         (n),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .swap_cnt  (swap_cnt),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // RAM model with a bench-side bulk load port
    logic [DW-1:0]    ram [DP];
    logic             load_req;
    logic [DP*DW-1:0] load_vec;

    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < int'(DP); k++) ram[k] <= load_vec[k*DW +: DW];
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    // Bus activity monitor
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int eq_cnt = 0;

    always @(posedge clk) begin
        if (mem_wr) wr_cnt++;
        if (mem_rd) rd_cnt++;
        if (mem_rd && mem_wr) both_cnt++;
        // WR_A overwriting a word with an equal value means equal elements swapped
        if (mem_wr && state_out == 4'd5 && mem_wdata == ram[mem_addr]) eq_cnt++;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ram_vec(input int nn);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < nn && k < int'(DP); k++) v[k*DW +: DW] = ram[k];
        return v;
    endfunction

    task automatic load(input logic [127:0] v);
        load_vec = v;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Start a sort and return the cycle (after the sampling edge) in which done is seen.
    task automatic run_sort(input int nn, input logic desc, input bit poke, output int lat);
        start   = 1'b1;
        descend = desc;
        n       = (AW+1)'(nn);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 3000; k++) begin
            if (poke && k == 5) begin
                start   = 1'b1;
                n       = (AW+1)'(2);
                descend = ~desc;
            end
            if (poke && k == 6) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    int lat;
    int wr0, rd0, eq0, wr_hold;
    int found;

    initial begin
        rst_n = 1'b0; start = 1'b0; descend = 1'b0; n = '0;
        load_req = 1'b0; load_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {busy, done, mem_rd, mem_wr}, 4'b0000);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_swap", swap_cnt, 0);
        chk("rst_state", state_out, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // [3,1,4,2] ascending, with a start pulse while busy
        load(128'h02040103);
        wr0 = wr_cnt; rd0 = rd_cnt;
        run_sort(4, 1'b0, 1'b1, lat);
        chk("t1_lat", lat, 34);
        chk("t1_swap", swap_cnt, 3);
        chk("t1_ram", ram_vec(4), 128'h04030201);
        chk("t1_rd", rd_cnt - rd0, 12);
        chk("t1_wr", wr_cnt - wr0, 6);
        @(posedge clk);
        #1;
        chk("t1_post", {busy, done, state_out}, 6'b000000);
        chk("t1_hold", swap_cnt, 3);

        // already sorted ascending
        load(128'h04030201);
        wr0 = wr_cnt;
        run_sort(4, 1'b0, 1'b0, lat);
`ifdef SORT_EARLY_EXIT_EN
        chk("t2_lat", lat, 14);
`else
        chk("t2_lat", lat, 28);
`endif
        chk("t2_swap", swap_cnt, 0);
        chk("t2_wr", wr_cnt - wr0, 0);
        chk("t2_ram", ram_vec(4), 128'h04030201);
        @(posedge clk);
        #1;

        // [2,2,7,0,7] descending: stable, 5 swaps
        load(128'h0700070202);
        eq0 = eq_cnt;
        run_sort(5, 1'b1, 1'b0, lat);
        chk("t3_lat", lat, 55);
        chk("t3_swap", swap_cnt, 5);
        chk("t3_ram", ram_vec(5), 128'h0002020707);
        chk("t3_eqswap", eq_cnt - eq0, 0);
        @(posedge clk);
        #1;

        // n = 1 and n = 0: immediate done, no RAM access
        wr0 = wr_cnt; rd0 = rd_cnt;
        run_sort(1, 1'b0, 1'b0, lat);
        chk("t4_lat_n1", lat, 1);
        chk("t4_swap_n1", swap_cnt, 0);
        @(posedge clk);
        #1;
        chk("t4_post_n1", {busy, done}, 2'b00);
        run_sort(0, 1'b1, 1'b0, lat);
        chk("t4_lat_n0", lat, 1);
        chk("t4_swap_n0", swap_cnt, 0);
        @(posedge clk);
        #1;
        chk("t4_rdwr", {rd_cnt - rd0, wr_cnt - wr0}, 0);
        chk("t4_ram", ram_vec(5), 128'h0002020707);

        // n = 20 clipped to 16, reverse order input
        load(128'h000102030405060708090a0b0c0d0e0f);
        run_sort(20, 1'b0, 1'b0, lat);
        chk("t5_lat", lat, 736);
        chk("t5_swap", swap_cnt, 120);
        chk("t5_ram", ram_vec(16), 128'h0f0e0d0c0b0a09080706050403020100);
        @(posedge clk);
        #1;

        // reset during the first WR_A
        load(128'h02040103);
        start = 1'b1; descend = 1'b0; n = (AW+1)'(4);
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (state_out == 4'd5) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("t6_reach_wra", found, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_state", state_out, 0);
        chk("t6_ctrl", {busy, done, mem_wr, mem_rd}, 4'b0000);
        wr_hold = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_nowr", wr_cnt - wr_hold, 0);
        chk("t6_swap", swap_cnt, 0);

        // fresh sort after reset, descending
        load(128'h02040103);
        run_sort(4, 1'b1, 1'b0, lat);
        chk("t7_lat", lat, 34);
        chk("t7_swap", swap_cnt, 3);
        chk("t7_ram", ram_vec(4), 128'h01020304);
        @(posedge clk);
        #1;

        chk("rd_wr_overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
